// File: rtl/ysyx_22041207_lsu_pkg.sv
// Shared types and helpers for the NPC load/store unit: FSM states, access
// size codes, bus geometry and load-result extension.
package ysyx_22041207_lsu_pkg;

    localparam int unsigned MAX_DATA_W = 64;

    function automatic int unsigned bus_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    localparam int unsigned B = bus_bytes(MAX_DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } lsu_size_e;

    // Keeps the low 2^size bytes of data and fills the rest with zeros or the top bit.
    function automatic logic [MAX_DATA_W-1:0] extend(input logic [MAX_DATA_W-1:0] data,
                                                     input lsu_size_e             size,
                                                     input logic                  sext);
        logic [MAX_DATA_W-1:0] r;
        case (size)
            SZ_BYTE: r = {{(8*(B-1)){sext & data[7]}},  data[7:0]};
            SZ_HALF: r = {{(8*(B-2)){sext & data[15]}}, data[15:0]};
            SZ_WORD: r = {{(8*(B-4)){sext & data[31]}}, data[31:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22041207_lsu_align.sv
// Combinational lane logic for the LSU: beat address, shifted write data and
// byte mask, read-data merging and final load extraction.
module ysyx_22041207_lsu_align
    import ysyx_22041207_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic [ADDR_W-1:0]   addr_i,
    input  lsu_size_e           size_i,
    input  logic                beat1_i,
    input  logic                wen_i,
    input  logic                sext_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic [DATA_W-1:0]   acc_i,
    output logic                cross_o,
    output logic                oversize_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    output logic [DATA_W-1:0]   acc_d_o,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned NB    = bus_bytes(DATA_W);
    localparam int unsigned OFF_W = $clog2(NB);

    logic [31:0]       off_u;
    logic [31:0]       n_u;
    logic [31:0]       sh0;
    logic [31:0]       sh1;
    logic [NB-1:0]     full;
    logic [ADDR_W-1:0] base;

    always_comb begin
        off_u = 32'(addr_i[OFF_W-1:0]);
        n_u   = 32'd1 << size_i;
        sh0   = off_u << 3;
        sh1   = (32'(NB) - off_u) << 3;
        // Wraps to all-ones when n equals the bus width.
        full  = (NB'(1) << n_u) - NB'(1);
        base  = addr_i & ~ADDR_W'(NB - 1);
    end

    assign cross_o    = (off_u + n_u) > 32'(NB);
    assign oversize_o = n_u > 32'(NB);

    always_comb begin
        if (beat1_i) begin
            mem_addr_o  = base + ADDR_W'(NB);
            mem_wdata_o = wdata_i >> sh1;
            mem_wmask_o = wen_i ? (full >> (32'(NB) - off_u)) : '0;
            acc_d_o     = acc_i | (mem_rdata_i << sh1);
        end else begin
            mem_addr_o  = base;
            mem_wdata_o = wdata_i << sh0;
            mem_wmask_o = wen_i ? (full << off_u) : '0;
            acc_d_o     = mem_rdata_i >> sh0;
        end
    end

    assign rdata_o = DATA_W'(extend(MAX_DATA_W'(acc_i), size_i, sext_i));

endmodule

// File: rtl/ysyx_22041207_lsu.sv
// Load/store unit: handshaked request in, one or two aligned bus beats out,
// extended load data or an error flag back as the response.
module ysyx_22041207_lsu
    import ysyx_22041207_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned DATA_W   = 64,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                mem_valid,
    input  logic                mem_ack,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              wen_q, wen_d;
    logic              sext_q, sext_d;
    logic              err_q, err_d;
    lsu_size_e         size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic                al_cross, al_oversize;
    logic [ADDR_W-1:0]   al_addr, al_mem_addr;
    lsu_size_e           al_size;
    logic [DATA_W-1:0]   al_wdata, al_acc_d, al_rdata;
    logic [DATA_W/8-1:0] al_wmask;

    // In IDLE the aligner looks at the incoming request so legality is known at accept time.
    assign al_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign al_size = (state_q == ST_IDLE) ? lsu_size_e'(req_size) : size_q;

    ysyx_22041207_lsu_align #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_align (
        .addr_i      (al_addr),
        .size_i      (al_size),
        .beat1_i     (state_q == ST_BEAT1),
        .wen_i       (wen_q),
        .sext_i      (sext_q),
        .wdata_i     (wdata_q),
        .mem_rdata_i (mem_rdata),
        .acc_i       (acc_q),
        .cross_o     (al_cross),
        .oversize_o  (al_oversize),
        .mem_addr_o  (al_mem_addr),
        .mem_wdata_o (al_wdata),
        .mem_wmask_o (al_wmask),
        .acc_d_o     (al_acc_d),
        .rdata_o     (al_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wen_q   <= 1'b0;
            sext_q  <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            sext_q  <= sext_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        sext_d  = sext_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    sext_d  = req_sext;
                    size_d  = lsu_size_e'(req_size);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    acc_d   = '0;
                    err_d   = al_oversize | (al_cross & !SPLIT_EN);
                    state_d = (al_oversize | (al_cross & !SPLIT_EN)) ? ST_RESP : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                if (mem_ack) begin
                    acc_d   = al_acc_d;
                    state_d = al_cross ? ST_BEAT1 : ST_RESP;
                end
            end
            ST_BEAT1: begin
                if (mem_ack) begin
                    acc_d   = al_acc_d;
                    state_d = ST_RESP;
                end
            end
            default: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        mem_valid = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
        mem_wen   = mem_valid & wen_q;
        mem_addr  = mem_valid ? al_mem_addr : '0;
        mem_wdata = mem_valid ? al_wdata : '0;
        mem_wmask = mem_valid ? al_wmask : '0;
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = rsp_valid & err_q;
        rsp_rdata = (rsp_valid && !wen_q && !err_q) ? al_rdata : '0;
    end

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
// Directed self-checking bench for ysyx_22041207_lsu: a 64-bit splitting
// instance, a 64-bit non-splitting instance and a 32-bit instance.
module tb_ysyx_22041207_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid_ns, req_valid_32;
    logic        req_wen, req_sext, rsp_ready, mem_ack;
    logic [63:0] req_addr, req_wdata, mem_rdata;
    logic [1:0]  req_size;

    logic        req_ready, rsp_valid, rsp_err, mem_valid, mem_wen;
    logic [63:0] rsp_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;

    logic        ns_req_ready, ns_rsp_valid, ns_rsp_err, ns_mem_valid, ns_mem_wen;
    logic [63:0] ns_rsp_rdata, ns_mem_addr, ns_mem_wdata;
    logic [7:0]  ns_mem_wmask;

    logic        e_req_ready, e_rsp_valid, e_rsp_err, e_mem_valid, e_mem_wen;
    logic [31:0] e_rsp_rdata, e_mem_wdata;
    logic [63:0] e_mem_addr;
    logic [3:0]  e_mem_wmask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22041207_lsu #(.ADDR_W(64), .DATA_W(64), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_sext(req_sext), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ack(mem_ack), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata)
    );

    ysyx_22041207_lsu #(.ADDR_W(64), .DATA_W(64), .SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_ns), .req_ready(ns_req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_sext(req_sext), .rsp_valid(ns_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err),
        .mem_valid(ns_mem_valid), .mem_ack(mem_ack), .mem_wen(ns_mem_wen),
        .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata), .mem_wmask(ns_mem_wmask),
        .mem_rdata(mem_rdata)
    );

    ysyx_22041207_lsu #(.ADDR_W(64), .DATA_W(32), .SPLIT_EN(1'b1)) dut_32 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_32), .req_ready(e_req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .req_size(req_size), .req_sext(req_sext), .rsp_valid(e_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(e_rsp_rdata), .rsp_err(e_rsp_err),
        .mem_valid(e_mem_valid), .mem_ack(mem_ack), .mem_wen(e_mem_wen),
        .mem_addr(e_mem_addr), .mem_wdata(e_mem_wdata), .mem_wmask(e_mem_wmask),
        .mem_rdata(mem_rdata[31:0])
    );

    // Presents a request to instance sel (0 main, 1 no-split, 2 32-bit) and returns at
    // the falling edge of the cycle after the accepting clock edge (cycle T+1).
    task automatic issue(input int sel, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [1:0] size, input logic sext);
        logic rdy;
        int   waited;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_sext  = sext;
        req_valid    = (sel == 0);
        req_valid_ns = (sel == 1);
        req_valid_32 = (sel == 2);
        waited = 0;
        rdy = (sel == 0) ? req_ready : (sel == 1) ? ns_req_ready : e_req_ready;
        while (!rdy && waited < 20) begin
            @(negedge clk);
            waited++;
            rdy = (sel == 0) ? req_ready : (sel == 1) ? ns_req_ready : e_req_ready;
        end
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_timeout: req_ready=%b after %0d cycles, required 1", rdy, waited);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
        req_valid_ns = 1'b0;
        req_valid_32 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err); end
        n_checks++; if (rsp_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h required 0", rsp_rdata); end
        n_checks++; if ({mem_valid, mem_wen} !== 2'b00) begin n_fail++; $display("FAIL rst_mem_ctl: got %b required 00", {mem_valid, mem_wen}); end
        n_checks++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_wmask !== 8'h0) begin n_fail++; $display("FAIL rst_mem_bus: got %h/%h/%h required 0/0/0", mem_addr, mem_wdata, mem_wmask); end
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_store();
        mem_ack = 1'b1;
        issue(0, 1'b1, 64'h80000000, 64'h1122334455667788, 2'd3, 1'b0);
        n_checks++; if ({mem_valid, mem_wen} !== 2'b11) begin n_fail++; $display("FAIL ast_mem_ctl: got %b required 11", {mem_valid, mem_wen}); end
        n_checks++; if (mem_addr !== 64'h80000000) begin n_fail++; $display("FAIL ast_addr: got %h required 80000000", mem_addr); end
        n_checks++; if (mem_wmask !== 8'hFF) begin n_fail++; $display("FAIL ast_wmask: got %h required ff", mem_wmask); end
        n_checks++; if (mem_wdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL ast_wdata: got %h required 1122334455667788", mem_wdata); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ast_rsp_early: got %b required 0", rsp_valid); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL ast_rsp_t2: rsp_valid=%b mem_valid=%b required 1/0", rsp_valid, mem_valid); end
        n_checks++; if (rsp_rdata !== 64'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL ast_rsp_data: got %h err %b required 0 err 0", rsp_rdata, rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_split_store();
        mem_ack = 1'b1;
        issue(0, 1'b1, 64'h80000006, 64'h00000000AABBCCDD, 2'd2, 1'b0);
        n_checks++; if (mem_addr !== 64'h80000000 || mem_wmask !== 8'hC0) begin n_fail++; $display("FAIL sst_b0_addr_mask: got %h/%h required 80000000/c0", mem_addr, mem_wmask); end
        n_checks++; if (mem_wdata !== 64'hCCDD000000000000) begin n_fail++; $display("FAIL sst_b0_wdata: got %h required ccdd000000000000", mem_wdata); end
        @(negedge clk);
        n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 64'h80000008 || mem_wmask !== 8'h03) begin n_fail++; $display("FAIL sst_b1_addr_mask: got v%b %h/%h required v1 80000008/03", mem_valid, mem_addr, mem_wmask); end
        n_checks++; if (mem_wdata !== 64'h000000000000AABB) begin n_fail++; $display("FAIL sst_b1_wdata: got %h required aabb", mem_wdata); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0) begin n_fail++; $display("FAIL sst_rsp_t3: got v%b %h required v1 0", rsp_valid, rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_byte_load();
        logic [63:0] exp_r [2];
        exp_r[0] = 64'h0000000000000080;
        exp_r[1] = 64'hFFFFFFFFFFFFFF80;
        mem_ack = 1'b1;
        for (int s = 1; s >= 0; s--) begin
            issue(0, 1'b0, 64'h80000003, 64'h0, 2'd0, s[0]);
            mem_rdata = 64'h0000000080000000;
            n_checks++; if (mem_addr !== 64'h80000000 || mem_wmask !== 8'h00 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL bld_beat sext=%0d: got %h/%h/w%b required 80000000/00/w0", s, mem_addr, mem_wmask, mem_wen); end
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_r[s]) begin n_fail++; $display("FAIL bld_rdata sext=%0d: got v%b %h required v1 %h", s, rsp_valid, rsp_rdata, exp_r[s]); end
            @(negedge clk);
        end
    endtask

    task automatic test_split_load();
        mem_ack = 1'b1;
        issue(0, 1'b0, 64'h80000004, 64'h0, 2'd3, 1'b0);
        mem_rdata = 64'h44332211DEADBEEF;
        n_checks++; if (mem_addr !== 64'h80000000 || mem_wmask !== 8'h00) begin n_fail++; $display("FAIL sld_b0: got %h/%h required 80000000/00", mem_addr, mem_wmask); end
        @(negedge clk);
        mem_rdata = 64'hCAFEBABE88776655;
        n_checks++; if (mem_addr !== 64'h80000008) begin n_fail++; $display("FAIL sld_b1_addr: got %h required 80000008", mem_addr); end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h8877665544332211) begin n_fail++; $display("FAIL sld_rdata: got v%b %h required v1 8877665544332211", rsp_valid, rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_no_split_error();
        issue(1, 1'b0, 64'h80000007, 64'h0, 2'd1, 1'b0);
        n_checks++; if (ns_rsp_valid !== 1'b1 || ns_rsp_err !== 1'b1) begin n_fail++; $display("FAIL ns_err_t1: got v%b e%b required v1 e1", ns_rsp_valid, ns_rsp_err); end
        n_checks++; if (ns_mem_valid !== 1'b0 || ns_rsp_rdata !== 64'h0) begin n_fail++; $display("FAIL ns_no_beat: got mv%b %h required mv0 0", ns_mem_valid, ns_rsp_rdata); end
        @(negedge clk);
        n_checks++; if (ns_req_ready !== 1'b1 || ns_mem_valid !== 1'b0) begin n_fail++; $display("FAIL ns_back_idle: got rdy%b mv%b required rdy1 mv0", ns_req_ready, ns_mem_valid); end
    endtask

    task automatic test_data32();
        issue(2, 1'b0, 64'h80000000, 64'h0, 2'd3, 1'b1);
        n_checks++; if (e_rsp_valid !== 1'b1 || e_rsp_err !== 1'b1 || e_mem_valid !== 1'b0) begin n_fail++; $display("FAIL d32_oversize: got v%b e%b mv%b required v1 e1 mv0", e_rsp_valid, e_rsp_err, e_mem_valid); end
        @(negedge clk);
        mem_ack = 1'b1;
        issue(2, 1'b1, 64'h80000002, 64'h00000000AABBCCDD, 2'd2, 1'b0);
        n_checks++; if (e_mem_addr !== 64'h80000000 || e_mem_wmask !== 4'hC || e_mem_wdata !== 32'hCCDD0000) begin n_fail++; $display("FAIL d32_b0: got %h/%h/%h required 80000000/c/ccdd0000", e_mem_addr, e_mem_wmask, e_mem_wdata); end
        @(negedge clk);
        n_checks++; if (e_mem_addr !== 64'h80000004 || e_mem_wmask !== 4'h3 || e_mem_wdata !== 32'h0000AABB) begin n_fail++; $display("FAIL d32_b1: got %h/%h/%h required 80000004/3/0000aabb", e_mem_addr, e_mem_wmask, e_mem_wdata); end
        @(negedge clk);
        n_checks++; if (e_rsp_valid !== 1'b1 || e_rsp_err !== 1'b0) begin n_fail++; $display("FAIL d32_rsp: got v%b e%b required v1 e0", e_rsp_valid, e_rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        mem_ack = 1'b1;
        issue(0, 1'b0, 64'h80000010, 64'h0, 2'd3, 1'b0);
        mem_ack   = 1'b0;
        mem_rdata = 64'h0123456789ABCDEF;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 64'h80000010 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold T+%0d: got mv%b %h rv%b required mv1 80000010 rv0", c, mem_valid, mem_addr, rsp_valid); end
        end
        mem_ack = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL stall_rsp_t5: got v%b %h required v1 0123456789abcdef", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0123456789ABCDEF || req_ready !== 1'b0) begin n_fail++; $display("FAIL rsp_hold %0d: got v%b %h rdy%b required v1 0123456789abcdef rdy0", c, rsp_valid, rsp_rdata, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rsp_release: got v%b rdy%b required v0 rdy1", rsp_valid, req_ready); end
    endtask

    task automatic test_reset_mid_beat();
        mem_ack = 1'b1;
        issue(0, 1'b1, 64'h80000006, 64'h00000000AABBCCDD, 2'd2, 1'b0);
        @(negedge clk);
        mem_ack = 1'b0;
        n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 64'h80000008) begin n_fail++; $display("FAIL rmb_in_beat1: got mv%b %h required mv1 80000008", mem_valid, mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_valid !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 64'h0 || mem_wmask !== 8'h0 || mem_wdata !== 64'h0) begin n_fail++; $display("FAIL rmb_async_clear: got mv%b w%b %h/%h/%h required all 0", mem_valid, mem_wen, mem_addr, mem_wmask, mem_wdata); end
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_state: got rdy%b rv%b required rdy1 rv0", req_ready, rsp_valid); end
        #1 rst_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 64'h80000005, 64'h0, 2'd0, 1'b0);
        mem_rdata = 64'h0000AB0000000000;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h00000000000000AB) begin n_fail++; $display("FAIL rmb_next_req: got v%b %h required v1 ab", rsp_valid, rsp_rdata); end
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_valid_ns = 1'b0;
        req_valid_32 = 1'b0;
        req_wen      = 1'b0;
        req_sext     = 1'b0;
        req_addr     = 64'h0;
        req_wdata    = 64'h0;
        req_size     = 2'd0;
        rsp_ready    = 1'b1;
        mem_ack      = 1'b1;
        mem_rdata    = 64'h0;
        test_reset();
        test_aligned_store();
        test_split_store();
        test_byte_load();
        test_split_load();
        test_no_split_error();
        test_data32();
        test_stall();
        test_reset_mid_beat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_lsu.md
# ysyx_22041207_lsu

Parametrised load/store unit between the execute stage and the data-memory port of the NPC core. It accepts one load or store per handshake. Accesses that cross a bus-word boundary are split into two aligned bus beats with shifted data and byte masks. Load results are sign- or zero-extended to the full data width. Unlike the single-cycle memory stage it replaces, it uses valid/ready handshakes on both sides, tolerates multi-cycle memory latency, and reports illegal accesses.

## Interface
Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus and register data width; power of two, 32 or 64.
- SPLIT_EN, 1, 1 splits boundary-crossing accesses; 0 flags them as errors.

Ports:
- clk  in  1  clock. One clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- req_size  in  2  log2 of bytes: 0=1, 1=2, 2=4, 3=8.
- req_sext  in  1  sign-extend load result.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores.
- rsp_err  out  1  illegal access.
- mem_valid  out  1  bus beat request.
- mem_ack  in  1  beat complete; mem_rdata is valid in the same cycle.
- mem_wen  out  1  beat is a write.
- mem_addr  out  ADDR_W  DATA_W/8-aligned address.
- mem_wdata  out  DATA_W  lane-shifted write data.
- mem_wmask  out  DATA_W/8  byte enables.
- mem_rdata  in  DATA_W  read data.

## Operation
- Derived values:
  - B = DATA_W/8.
  - off = req_addr mod B.
  - n = 1<<req_size.
  - full = (1<<n)-1.
  - cross = off+n > B.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On handshake, capture the request and go to:
  - RESP with err=1 if n > B, or if cross and SPLIT_EN=0. No bus beat is issued.
  - BEAT0 otherwise.
- BEAT0 outputs:
  - mem_addr = addr & ~(B-1).
  - mem_wdata = wdata << 8*off.
  - mem_wmask = (full << off) truncated to B bits.
- BEAT0 on mem_ack:
  - Store the low part as mem_rdata >> 8*off.
  - Go to BEAT1 if cross, else RESP.
- BEAT1 outputs:
  - mem_addr = aligned address + B.
  - mem_wdata = wdata >> 8*(B-off).
  - mem_wmask = full >> (B-off).
- BEAT1 on mem_ack: OR mem_rdata << 8*(B-off) into the stored data, then go to RESP.
- RESP: rsp_valid=1.
  - For a load, rsp_rdata keeps the low n bytes, extended per sext.
  - For a store, rsp_rdata = 0.
  - Hold all outputs until rsp_ready, then return to IDLE.
- mem_valid, mem_wen, mem_addr, mem_wdata and mem_wmask stay stable from assertion until mem_ack.
- mem_wmask is 0 for reads.

## Timing
- Reset values:
  - State IDLE, so req_ready=1.
  - rsp_valid, rsp_rdata, rsp_err = 0.
  - mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask = 0.
- Latency, for a request accepted at cycle T with zero-wait memory:
  - Single beat: mem_valid at T+1, rsp_valid at T+2.
  - Split: BEAT1 at T+2, rsp_valid at T+3.
  - Error: rsp_valid at T+1.
- Each mem_ack stall cycle adds one cycle of latency.
- Only one request is in flight at a time. A new request can be accepted the cycle after the RESP handshake.
- mem_ack outside BEAT0/BEAT1 is ignored.
- Reset asserted mid-operation: all outputs clear immediately, and any in-flight beat is abandoned. The memory model must drop it.
- All width arithmetic is in DATA_W bits. Shifts of ≥ DATA_W yield 0.

## Structure
- Package ysyx_22041207_lsu_pkg holds:
  - the state enum;
  - the size codes;
  - B;
  - an extend(data, size, sext) function.
- Sub-module ysyx_22041207_lsu_align contains the combinational logic for mask and shift generation per beat and final extraction. The FSM and registers stay in the top level.

## Test plan
- Aligned store, DATA_W=64: size 3, addr 0x80000000, wdata 0x1122334455667788.
  - One beat: mem_addr 0x80000000, wmask 0xFF.
  - rsp_valid at T+2, rdata 0.
- Split store: size 2, addr 0x80000006, wdata 0xAABBCCDD.
  - Beat 0: addr 0x80000000, wmask 0xC0, wdata 0xCCDD000000000000.
  - Beat 1: addr 0x80000008, wmask 0x03, wdata 0xAABB.
- Byte load: addr 0x80000003, mem_rdata 0x0000000080000000.
  - sext=1 gives rsp_rdata 0xFFFFFFFFFFFFFF80.
  - sext=0 gives 0x80.
- Split load: size 3, addr 0x80000004.
  - Beat 0 mem_rdata 0x44332211DEADBEEF; beat 1 mem_rdata 0xCAFEBABE88776655.
  - Result 0x8877665544332211.
- SPLIT_EN=0, misaligned half-word at offset 7:
  - No mem_valid.
  - rsp_err=1 at T+1.
  - Also check size 3 with DATA_W=32 gives the same error response.
- Stall and reset:
  - mem_ack held low 3 cycles gives latency T+5.
  - rsp_ready held low keeps outputs stable.
  - rst_n pulsed during BEAT1 clears outputs asynchronously; the next request then completes normally.
